// File: rtl/sys_os_pkg.sv
// Shared types and width helpers for the output-stationary drain collector.
package sys_os_pkg;

    typedef enum logic {COLLECT, STREAM} drain_state_t;

    localparam int DEF_D_W = 8;
    localparam int DEF_N   = 3;

    function automatic int res_w(input int d_w);
        return 2 * d_w;
    endfunction

    // Index width is kept at least 1 so a 1x1 array still has addressable ports.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int RES_W = res_w(DEF_D_W);
    localparam int IDX_W = idx_w(DEF_N);
    localparam int CNT_W = cnt_w(DEF_N);

endpackage

// File: rtl/drain_row_capture.sv
// One row of the tile buffer: counts drained values and stores them at
// reversed column positions, since the array drains col N-1 first.
module drain_row_capture
    import sys_os_pkg::*;
#(
    parameter int D_W = DEF_D_W,
    parameter int N   = DEF_N
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    collect,
    input  logic                    clear,
    input  logic                    valid,
    input  logic [res_w(D_W)-1:0]   data,
    input  logic [idx_w(N)-1:0]     rd_col,
    output logic [res_w(D_W)-1:0]   rd_data,
    output logic                    row_full,
    output logic                    row_overflow
);

    localparam int RW = res_w(D_W);
    localparam int IW = idx_w(N);
    localparam int CW = cnt_w(N);
    localparam logic [CW-1:0] CNT_MAX = CW'(N);

    logic [CW-1:0] cnt;
    logic [RW-1:0] row_buf [N];
    logic [IW-1:0] wr_idx;
    logic          capture;

    assign capture      = collect && valid && (cnt != CNT_MAX);
    assign wr_idx       = IW'(N - 1 - int'(cnt));
    assign row_overflow = valid && !capture;
    // Full includes a capture of the final value in this same cycle.
    assign row_full     = (cnt == CNT_MAX) || (capture && (cnt == CNT_MAX - CW'(1)));
    assign rd_data      = row_buf[rd_col];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (capture) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            row_buf[wr_idx] <= data;
        end
    end

endmodule

// File: rtl/os_drain_collector.sv
// Collects one N x N result tile from the array's per-row drain and streams it
// out row-major over valid/ready.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  COLLECT | rows capture drained values; waits until every row holds N
//  STREAM  | buffer read out row-major; new drain values are overflow
module os_drain_collector
    import sys_os_pkg::*;
#(
    parameter int D_W = DEF_D_W,
    parameter int N   = DEF_N
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N-1:0][res_w(D_W)-1:0]    m2,
    input  logic [N-1:0]                    valid_m2,
    output logic [res_w(D_W)-1:0]           out_data,
    output logic [idx_w(N)-1:0]             out_row,
    output logic [idx_w(N)-1:0]             out_col,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            tile_done,
    output logic                            busy,
    output logic                            overflow
);

    localparam int RW = res_w(D_W);
    localparam int IW = idx_w(N);
    localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

    drain_state_t  state;
    logic [IW-1:0] rp;
    logic [IW-1:0] cp;
    logic [IW-1:0] rp_nxt;
    logic [IW-1:0] cp_nxt;
    logic          cp_wrap;
    logic          hs;
    logic          last_hs;
    logic [N-1:0]  row_full;
    logic [N-1:0]  row_ovf;
    logic [RW-1:0] row_rd [N];

    assign hs        = out_valid && out_ready;
    assign last_hs   = hs && out_last;
    assign tile_done = last_hs;

    assign cp_wrap = (cp == IDX_MAX);
    assign cp_nxt  = cp_wrap ? '0 : cp + IW'(1);
    assign rp_nxt  = cp_wrap ? rp + IW'(1) : rp;

    for (genvar g = 0; g < N; g++) begin : g_row
        drain_row_capture #(
            .D_W (D_W),
            .N   (N)
        ) u_row (
            .clk          (clk),
            .rst          (rst),
            .collect      (state == COLLECT),
            .clear        (last_hs),
            .valid        (valid_m2[g]),
            .data         (m2[g]),
            .rd_col       (cp),
            .rd_data      (row_rd[g]),
            .row_full     (row_full[g]),
            .row_overflow (row_ovf[g])
        );
    end

    assign out_data = row_rd[rp];
    assign out_row  = rp;
    assign out_col  = cp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            rp        <= '0;
            cp        <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (|row_ovf) begin
                overflow <= 1'b1;
            end
            case (state)
                COLLECT: begin
                    if (&row_full) begin
                        state     <= STREAM;
                        rp        <= '0;
                        cp        <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_last  <= (N == 1);
                    end
                end
                STREAM: begin
                    if (last_hs) begin
                        state     <= COLLECT;
                        rp        <= '0;
                        cp        <= '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        out_last  <= 1'b0;
                    end else if (hs) begin
                        rp       <= rp_nxt;
                        cp       <= cp_nxt;
                        out_last <= (rp_nxt == IDX_MAX) && (cp_nxt == IDX_MAX);
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_os_drain_collector.sv
// Randomized bench for os_drain_collector (D_W=8, N=3) against a tile-level
// reference model: drained values land at reversed columns, stream row-major.
module tb_os_drain_collector;

    localparam int D_W = 8;
    localparam int N   = 3;
    localparam int RW  = 2 * D_W;

    typedef logic [RW-1:0] tile_t [N][N];
    typedef int row_int_t [N];

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N-1:0][RW-1:0]   m2;
    logic [N-1:0]           valid_m2;
    logic [RW-1:0]          out_data;
    logic [1:0]             out_row;
    logic [1:0]             out_col;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic                   tile_done;
    logic                   busy;
    logic                   overflow;

    os_drain_collector #(.D_W(D_W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .m2        (m2),
        .valid_m2  (valid_m2),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .tile_done (tile_done),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_stream = 0;
    int          m_cnt [N];
    logic [RW-1:0] m_buf [N][N];
    int          m_idx = 0;
    bit          m_ovf = 0;

    int cyc;
    int first_valid_cyc;
    int beats;
    int stall_cnt;
    int abort_beat = -1;
    bit aborted;

    task automatic model_clear();
        m_stream = 0;
        m_idx    = 0;
        m_ovf    = 0;
        for (int r = 0; r < N; r++) m_cnt[r] = 0;
    endtask

    // One clock cycle: drive, check against the model at the negedge, advance model.
    task automatic step(input logic [N-1:0] vm, input logic [N-1:0][RW-1:0] d, input logic rdy);
        int r, c;
        bit all_full;
        bit exp_done;
        valid_m2  = vm;
        m2        = d;
        out_ready = rdy;
        #4;
        checks++;
        if (out_valid !== m_stream || busy !== m_stream) begin
            errors++;
            $display("FAIL valid_busy cyc=%0d got valid=%b busy=%b exp %b", cyc, out_valid, busy, m_stream);
        end
        checks++;
        if (overflow !== m_ovf) begin
            errors++;
            $display("FAIL overflow cyc=%0d got %b exp %b", cyc, overflow, m_ovf);
        end
        exp_done = m_stream && rdy && (m_idx == N*N-1);
        checks++;
        if (tile_done !== exp_done) begin
            errors++;
            $display("FAIL tile_done cyc=%0d got %b exp %b", cyc, tile_done, exp_done);
        end
        if (m_stream) begin
            r = m_idx / N;
            c = m_idx % N;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (!rdy) stall_cnt++;
            checks++;
            if (out_data !== m_buf[r][c] || out_row !== 2'(r) || out_col !== 2'(c)
                || out_last !== (m_idx == N*N-1)) begin
                errors++;
                $display("FAIL beat%0d cyc=%0d got data=%h row=%0d col=%0d last=%b exp data=%h row=%0d col=%0d last=%b",
                         m_idx, cyc, out_data, out_row, out_col, out_last, m_buf[r][c], r, c, m_idx == N*N-1);
            end
        end
        if (m_stream && abort_beat == m_idx) begin
            #1 rst = 1'b1;
            #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || tile_done !== 1'b0) begin
                errors++;
                $display("FAIL async_reset got valid=%b busy=%b ovf=%b done=%b exp 0", out_valid, busy, overflow, tile_done);
            end
            rst        = 1'b0;
            valid_m2   = '0;
            out_ready  = 1'b0;
            model_clear();
            abort_beat = -1;
            aborted    = 1;
        end else if (!m_stream) begin
            all_full = 1;
            for (int k = 0; k < N; k++) begin
                if (vm[k]) begin
                    if (m_cnt[k] < N) begin
                        m_buf[k][N-1-m_cnt[k]] = d[k];
                        m_cnt[k]++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (m_cnt[k] != N) all_full = 0;
            end
            if (all_full) begin
                m_stream = 1;
                m_idx    = 0;
            end
        end else begin
            if (|vm) m_ovf = 1;
            if (rdy) begin
                beats++;
                m_idx++;
                if (m_idx == N*N) begin
                    m_stream = 0;
                    m_idx    = 0;
                    for (int k = 0; k < N; k++) m_cnt[k] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drain one tile with per-row start offsets and optional gap/stall/overflow events.
    task automatic drain_tile(input tile_t tile, input row_int_t start, input row_int_t gap_at,
                              input int gap_pct, input int ready_pct, input int stall_beat,
                              input int stall_len, input int extra_row, input int inject_beat);
        int sent [N];
        int stalls = 0;
        int c = 0;
        bit extra_done = 0;
        bit injected = 0;
        bit saw_stream = 0;
        logic [N-1:0] vm;
        logic [N-1:0][RW-1:0] d;
        logic rdy;
        for (int r = 0; r < N; r++) sent[r] = 0;
        first_valid_cyc = -1;
        cyc       = 0;
        beats     = 0;
        stall_cnt = 0;
        aborted   = 0;
        while (c < 400) begin
            vm = '0;
            d  = '0;
            if (!m_stream) begin
                for (int r = 0; r < N; r++) begin
                    if (c >= start[r] && sent[r] < N && c != gap_at[r]
                        && $urandom_range(99) >= 32'(gap_pct)) begin
                        vm[r] = 1'b1;
                        d[r]  = tile[r][N-1-sent[r]];
                        sent[r]++;
                    end else if (r == extra_row && sent[r] == N && !extra_done) begin
                        vm[r] = 1'b1;
                        d[r]  = 16'hdead;
                        extra_done = 1;
                    end
                end
            end else if (inject_beat >= 0 && m_idx == inject_beat && !injected) begin
                vm[2]    = 1'b1;
                d[2]     = 16'hbeef;
                injected = 1;
            end
            if (m_stream && m_idx == stall_beat && stalls < stall_len) begin
                rdy = 1'b0;
                stalls++;
            end else begin
                rdy = ($urandom_range(99) < 32'(ready_pct));
            end
            if (m_stream) saw_stream = 1;
            step(vm, d, rdy);
            c++;
            if (m_stream) saw_stream = 1;
            if (saw_stream && !m_stream) break;
        end
        checks++;
        if (c >= 400) begin
            errors++;
            $display("FAIL tile_timeout got %0d cycles exp < 400", c);
        end
    endtask

    function automatic tile_t rand_tile();
        tile_t t;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                t[r][c] = 16'($urandom);
        return t;
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        valid_m2  = '0;
        m2        = '0;
        out_ready = 1'b0;
        model_clear();
        #3;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || tile_done !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset got valid=%b busy=%b ovf=%b done=%b last=%b exp 0",
                     out_valid, busy, overflow, tile_done, out_last);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_aligned();
        tile_t t;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                t[r][c] = 16'(c + 1);
        drain_tile(t, '{0, 0, 0}, '{-1, -1, -1}, 0, 100, -1, 0, -1, -1);
        checks++;
        if (first_valid_cyc != 3 || beats != 9 || cyc != 12) begin
            errors++;
            $display("FAIL aligned got first=%0d beats=%0d cycles=%0d exp 3 9 12", first_valid_cyc, beats, cyc);
        end
    endtask

    task automatic test_skewed();
        tile_t t;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                t[r][c] = 16'(16 * r + c);
        drain_tile(t, '{0, 2, 0}, '{-1, -1, 1}, 0, 100, -1, 0, -1, -1);
        checks++;
        if (first_valid_cyc != 5 || beats != 9) begin
            errors++;
            $display("FAIL skewed got first=%0d beats=%0d exp 5 9", first_valid_cyc, beats);
        end
    endtask

    task automatic test_backpressure();
        drain_tile(rand_tile(), '{0, 0, 0}, '{-1, -1, -1}, 0, 100, 4, 4, -1, -1);
        checks++;
        if (beats != 9 || stall_cnt != 4) begin
            errors++;
            $display("FAIL backpressure got beats=%0d stalls=%0d exp 9 4", beats, stall_cnt);
        end
    endtask

    task automatic test_overflow();
        drain_tile(rand_tile(), '{0, 2, 2}, '{-1, -1, -1}, 0, 100, -1, 0, 0, 3);
        checks++;
        if (overflow !== 1'b1 || beats != 9) begin
            errors++;
            $display("FAIL overflow_set got ovf=%b beats=%0d exp 1 9", overflow, beats);
        end
        drain_tile(rand_tile(), '{0, 0, 0}, '{-1, -1, -1}, 20, 70, -1, 0, -1, -1);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky got %b exp 1", overflow);
        end
    endtask

    task automatic test_reset_mid_stream();
        abort_beat = 2;
        drain_tile(rand_tile(), '{0, 1, 0}, '{-1, -1, -1}, 0, 100, -1, 0, -1, -1);
        checks++;
        if (aborted != 1) begin
            errors++;
            $display("FAIL abort_reached got %0d exp 1", aborted);
        end
        drain_tile(rand_tile(), '{1, 0, 2}, '{-1, -1, -1}, 0, 100, -1, 0, -1, -1);
        checks++;
        if (beats != 9 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got beats=%0d ovf=%b exp 9 0", beats, overflow);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            drain_tile(rand_tile(), '{0, 0, 0}, '{-1, -1, -1}, 0, 100, -1, 0, -1, -1);
            checks++;
            if (first_valid_cyc != 3 || beats != 9 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back tile%0d got first=%0d beats=%0d ovf=%b exp 3 9 0",
                         i, first_valid_cyc, beats, overflow);
            end
        end
    endtask

    task automatic test_random();
        row_int_t st;
        for (int i = 0; i < 6; i++) begin
            for (int r = 0; r < N; r++) st[r] = int'($urandom_range(3));
            drain_tile(rand_tile(), st, '{-1, -1, -1}, 30, 60, -1, 0, -1, -1);
            checks++;
            if (beats != 9) begin
                errors++;
                $display("FAIL random tile%0d got beats=%0d exp 9", i, beats);
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_skewed();
        test_backpressure();
        test_random();
        test_overflow();
        test_reset_mid_stream();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
